// File: rtl/monitor_niveles_carga.sv
// Charge-level monitor: sums N_BAT battery readings and classifies the total into
// four one-hot levels, with hysteresis and a consecutive-sample debounce before commit.
module monitor_niveles_carga #(
  parameter int N_BAT     = 2,
  parameter int W         = 4,
  parameter int MAX_CARGA = 30,
  parameter int HYST      = 1,
  parameter int DEBOUNCE  = 3,
  localparam int TW       = W + $clog2(N_BAT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic [N_BAT*W-1:0]   carga,
  output logic [TW-1:0]        carga_total,
  output logic                 optimo,
  output logic                 aceptable,
  output logic                 regular,
  output logic                 critico,
  output logic                 nivel_cambio
);

  localparam int CW    = $clog2(DEBOUNCE + 1);
  localparam int U_OPT = (MAX_CARGA * 32'sd75) / 32'sd100;
  localparam int U_ACE = (MAX_CARGA * 32'sd50) / 32'sd100;
  localparam int U_REG = (MAX_CARGA * 32'sd25) / 32'sd100;
  localparam int D_OPT = (U_OPT > HYST) ? (U_OPT - HYST) : 32'sd0;
  localparam int D_ACE = (U_ACE > HYST) ? (U_ACE - HYST) : 32'sd0;
  localparam int D_REG = (U_REG > HYST) ? (U_REG - HYST) : 32'sd0;

  typedef enum logic [1:0] {
    CRITICO   = 2'd0,
    REGULAR   = 2'd1,
    ACEPTABLE = 2'd2,
    OPTIMO    = 2'd3
  } nivel_e;

  // Bit order matches {optimo, aceptable, regular, critico}.
  function automatic logic [3:0] onehot_of(input nivel_e n);
    logic [3:0] r;
    case (n)
      OPTIMO:    r = 4'b1000;
      ACEPTABLE: r = 4'b0100;
      REGULAR:   r = 4'b0010;
      CRITICO:   r = 4'b0001;
      default:   r = 4'b0001;
    endcase
    return r;
  endfunction

  logic [TW-1:0] carga_total_q, sum_d;
  logic          v1_q;
  nivel_e        state_q, pend_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    lvl_q;
  logic          cambio_q;
  nivel_e        up_d, dn_d, cand_d;
  logic          commit_d;
  int            tot_d;

  // Stage-1 adder: zero-extended sum of every reading.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_BAT; i++) begin
      sum_d = sum_d + TW'(carga[i*W +: W]);
    end
  end

  // Level candidate with hysteresis and the debounce count that would follow it.
  always_comb begin
    tot_d = int'(carga_total_q);
    if (tot_d >= U_OPT)      up_d = OPTIMO;
    else if (tot_d >= U_ACE) up_d = ACEPTABLE;
    else if (tot_d >= U_REG) up_d = REGULAR;
    else                     up_d = CRITICO;

    if (tot_d >= D_OPT)      dn_d = OPTIMO;
    else if (tot_d >= D_ACE) dn_d = ACEPTABLE;
    else if (tot_d >= D_REG) dn_d = REGULAR;
    else                     dn_d = CRITICO;

    if (up_d > state_q)      cand_d = up_d;
    else if (dn_d < state_q) cand_d = dn_d;
    else                     cand_d = state_q;

    if (cand_d == state_q)     cnt_d = '0;
    else if (cand_d != pend_q) cnt_d = CW'(1);
    else                       cnt_d = cnt_q + CW'(1);

    if (cand_d != state_q) commit_d = (cnt_d == CW'(DEBOUNCE));
    else                   commit_d = 1'b0;
  end

  // Sample register, debounce state and registered level outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carga_total_q <= '0;
      v1_q          <= 1'b0;
      state_q       <= CRITICO;
      pend_q        <= CRITICO;
      cnt_q         <= '0;
      lvl_q         <= 4'b0001;
      cambio_q      <= 1'b0;
    end else begin
      cambio_q <= 1'b0;
      if (sample_valid) begin
        carga_total_q <= sum_d;
        v1_q          <= 1'b1;
      end else begin
        v1_q          <= 1'b0;
      end
      // Idle cycles leave pending/count untouched so gaps do not restart debounce.
      if (v1_q) begin
        if ((cand_d != state_q) && (cand_d != pend_q)) begin
          pend_q <= cand_d;
        end
        if (commit_d) begin
          state_q  <= cand_d;
          lvl_q    <= onehot_of(cand_d);
          cambio_q <= 1'b1;
          cnt_q    <= '0;
        end else begin
          cnt_q    <= cnt_d;
        end
      end
    end
  end

  assign carga_total  = carga_total_q;
  assign optimo       = lvl_q[3];
  assign aceptable    = lvl_q[2];
  assign regular      = lvl_q[1];
  assign critico      = lvl_q[0];
  assign nivel_cambio = cambio_q;

endmodule
